// File: rtl/scan_enc_pkg.sv
// Shared types and helpers for the scan encoder.
// Optional feature macro used by the design: SCAN_ENC_COUNT_EN.
package scan_enc_pkg;

  // Largest request vector the helpers are sized for.
  localparam int MAX_WIDTH = 256;
  localparam int CNT_W     = $clog2(MAX_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    NONE
  } scan_enc_state_t;

  // Number of set bits in a (zero-extended) request vector.
  function automatic logic [CNT_W-1:0] onehot_count(input logic [MAX_WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/scan_encoder_prio.sv
// Combinational first-set-bit finder. Reports index 0 with found=0 when
// no bit is set, so callers see a clean zero index on an empty vector.
module scan_enc_prio #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b0,
  localparam int  IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan in reverse priority order so the highest-priority set bit is the
  // last one written and therefore wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx   = '0;
    found = 1'b0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_encoder.sv
// Sequential scan encoder: captures a request vector, then emits the index
// of each set bit one beat at a time, or a single "none" beat for zero.
// Optional feature: define SCAN_ENC_COUNT_EN to add out_cnt (popcount of
// the captured vector, held for all beats of that vector).
module scan_encoder
  import scan_enc_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
`ifdef SCAN_ENC_COUNT_EN
  output logic [IDX_W:0]   out_cnt,
`endif
  output logic             busy
);

  scan_enc_state_t  state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] prio_idx;
  logic             prio_found;
  logic [CNT_W-1:0] pend_cnt;

  scan_enc_prio #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec   (pend_q),
    .idx   (prio_idx),
    .found (prio_found)
  );

  assign pend_cnt  = onehot_count(MAX_WIDTH'(pend_q));

  // Outputs decode directly from state and the pending register, so they are
  // stable whenever the consumer stalls.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign out_none  = (state_q == NONE);
  assign out_idx   = prio_idx;
  assign out_last  = (state_q == NONE) ||
                     ((state_q == SCAN) && prio_found && (pend_cnt == CNT_W'(1)));

  // Next-state and pending-vector update.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d  = in_data;
          state_d = (in_data != '0) ? SCAN : NONE;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_d[prio_idx] = 1'b0;
          if (out_last) state_d = IDLE;
        end
      end
      NONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State and pending-vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef SCAN_ENC_COUNT_EN
  logic [IDX_W:0] cnt_q, cnt_d;

  // Popcount is latched at capture and held for the whole vector.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && in_valid) begin
      cnt_d = (IDX_W + 1)'(onehot_count(MAX_WIDTH'(in_data)));
    end
  end

  // Popcount register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_scan_encoder.sv
// Directed bench for scan_encoder: LSB/MSB-first ordering, zero vector,
// back-pressure, mid-scan reset and input hold-off during a scan.
module tb_scan_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Shared stimulus for the two WIDTH=8 instances.
  logic       in_valid, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_none, a_busy;
  logic [2:0] a_out_idx;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_none, b_busy;
  logic [2:0] b_out_idx;

  logic        w_in_valid;
  logic [15:0] w_in_data;
  logic        w_in_ready, w_out_valid, w_out_last, w_out_none, w_busy;
  logic [3:0]  w_out_idx;

`ifdef SCAN_ENC_COUNT_EN
  logic [3:0] a_out_cnt, b_out_cnt;
  logic [4:0] w_out_cnt;
`endif

  scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx),
    .out_last(a_out_last), .out_none(a_out_none),
`ifdef SCAN_ENC_COUNT_EN
    .out_cnt(a_out_cnt),
`endif
    .busy(a_busy)
  );

  scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx),
    .out_last(b_out_last), .out_none(b_out_none),
`ifdef SCAN_ENC_COUNT_EN
    .out_cnt(b_out_cnt),
`endif
    .busy(b_busy)
  );

  scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_idx(w_out_idx),
    .out_last(w_out_last), .out_none(w_out_none),
`ifdef SCAN_ENC_COUNT_EN
    .out_cnt(w_out_cnt),
`endif
    .busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_i;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0;
    step(); step();

    // Reset state.
    check("rst in_ready", a_in_ready, 1);
    check("rst out_valid", a_out_valid, 0);
    check("rst out_idx", a_out_idx, 0);
    check("rst out_last", a_out_last, 0);
    check("rst out_none", a_out_none, 0);
    check("rst busy", a_busy, 0);
    check("rst w16 in_ready", w_in_ready, 1);
`ifdef SCAN_ENC_COUNT_EN
    check("rst out_cnt", a_out_cnt, 0);
`endif

    // 8'b1010_0100: LSB-first 2,5,7 and MSB-first 7,5,2.
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA4;
    step();
    in_valid = 1'b0;
    check("a4 valid", a_out_valid, 1);
    check("a4 in_ready low", a_in_ready, 0);
    check("a4 busy", a_busy, 1);
    check("a4 lsb idx0", a_out_idx, 2);  check("a4 lsb last0", a_out_last, 0);
    check("a4 msb idx0", b_out_idx, 7);  check("a4 msb last0", b_out_last, 0);
`ifdef SCAN_ENC_COUNT_EN
    check("a4 cnt", a_out_cnt, 3);
`endif
    step();
    check("a4 lsb idx1", a_out_idx, 5);  check("a4 lsb last1", a_out_last, 0);
    check("a4 msb idx1", b_out_idx, 5);  check("a4 msb last1", b_out_last, 0);
    step();
    check("a4 lsb idx2", a_out_idx, 7);  check("a4 lsb last2", a_out_last, 1);
    check("a4 msb idx2", b_out_idx, 2);  check("a4 msb last2", b_out_last, 1);
`ifdef SCAN_ENC_COUNT_EN
    check("a4 cnt held", a_out_cnt, 3);
`endif
    step();
    check("a4 in_ready back", a_in_ready, 1);
    check("a4 valid done", a_out_valid, 0);

    // Zero vector: one NONE beat.
    in_valid = 1'b1; in_data = 8'h00;
    step();
    in_valid = 1'b0;
    check("zero valid", a_out_valid, 1);
    check("zero none", a_out_none, 1);
    check("zero last", a_out_last, 1);
    check("zero idx", a_out_idx, 0);
    check("zero in_ready", a_in_ready, 0);
`ifdef SCAN_ENC_COUNT_EN
    check("zero cnt", a_out_cnt, 0);
`endif
    step();
    check("zero in_ready back", a_in_ready, 1);
    check("zero none clr", a_out_none, 0);

    // All-ones vector with back-pressure between beats.
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_i = i;
      check($sformatf("ff idx%0d", i), a_out_idx, exp_i);
      check($sformatf("ff last%0d", i), a_out_last, (i == 7) ? 1 : 0);
      check($sformatf("ff none%0d", i), a_out_none, 0);
`ifdef SCAN_ENC_COUNT_EN
      check($sformatf("ff cnt%0d", i), a_out_cnt, 8);
`endif
      out_ready = 1'b0;
      step();
      check($sformatf("ff hold valid%0d", i), a_out_valid, 1);
      check($sformatf("ff hold idx%0d", i), a_out_idx, exp_i);
      check($sformatf("ff hold last%0d", i), a_out_last, (i == 7) ? 1 : 0);
      out_ready = 1'b1;
      step();
    end
    check("ff in_ready back", a_in_ready, 1);
    check("ff valid done", a_out_valid, 0);

    // Mid-scan reset discards the remaining bits.
    in_valid = 1'b1; in_data = 8'h18;
    step();
    in_valid = 1'b0;
    check("rs idx3", a_out_idx, 3);
    step();
    check("rs idx4", a_out_idx, 4);
    rst_n = 1'b0;
    step();
    check("rs valid", a_out_valid, 0);
    check("rs in_ready", a_in_ready, 1);
    check("rs busy", a_busy, 0);
    check("rs idx", a_out_idx, 0);
    check("rs last", a_out_last, 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_valid = 1'b0;
    check("rs new valid", a_out_valid, 1);
    check("rs new idx", a_out_idx, 0);
    check("rs new last", a_out_last, 1);
    check("rs new none", a_out_none, 0);
    step();
    check("rs new done", a_in_ready, 1);

    // WIDTH=16: held in_valid with other data is ignored until in_ready returns.
    w_in_valid = 1'b1; w_in_data = 16'h8001;
    step();
    w_in_data = 16'h00F0;
    check("w16 idx0", w_out_idx, 0);
    check("w16 last0", w_out_last, 0);
    check("w16 in_ready0", w_in_ready, 0);
    step();
    check("w16 idx15", w_out_idx, 15);
    check("w16 last15", w_out_last, 1);
    step();
    check("w16 in_ready back", w_in_ready, 1);
    check("w16 valid gap", w_out_valid, 0);
    step();
    w_in_valid = 1'b0;
    for (int i = 4; i < 8; i++) begin
      exp_i = i;
      check($sformatf("w16 held idx%0d", i), w_out_idx, exp_i);
      check($sformatf("w16 held last%0d", i), w_out_last, (i == 7) ? 1 : 0);
`ifdef SCAN_ENC_COUNT_EN
      check($sformatf("w16 cnt%0d", i), w_out_cnt, 4);
`endif
      step();
    end
    check("w16 final in_ready", w_in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
